// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode map, instruction field positions and the
// decoded-instruction record passed from decode to execute.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int IMM_WIDTH  = 13;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_IMM_LO = 6'h08;
    localparam logic [5:0] OP_IMM_HI = 6'h1F;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RD_HI     = 25;
    localparam int RD_LO     = 21;
    localparam int RS_HI     = 20;
    localparam int RS_LO     = 16;
    localparam int RT_HI     = 15;
    localparam int RT_LO     = 11;
    localparam int IMM_HI    = IMM_WIDTH - 1;
    localparam int IMM_LO    = 0;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [5:0]            opcode;
        logic [4:0]            rd;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [IMM_WIDTH-1:0]  imm;
        logic                  isImm;
        logic                  illegal;
    } decodedInstrT;

endpackage

// File: rtl/instr_skid_buffer.sv
// Two-entry (main + skid) pipeline register with valid/ready handshake and flush.
// Output payload and handshake signals all come straight from flops.
module instr_skid_buffer
    import cpu_pkg::*;
#(
    parameter type T = decodedInstrT
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic inValid,
    output logic inReady,
    input  T     inData,
    output logic outValid,
    input  logic outReady,
    output T     outData
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufStateT;

    bufStateT stateReg;
    T         mainReg;
    T         skidReg;
    logic     outValidReg;
    logic     inReadyReg;

    logic accept;
    logic drain;

    assign accept   = inValid & inReadyReg;
    assign drain    = outValidReg & outReady;
    assign inReady  = inReadyReg;
    assign outValid = outValidReg;
    assign outData  = mainReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= EMPTY;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            mainReg     <= '0;
            skidReg     <= '0;
        end else if (flush) begin
            // Held payloads are left in place; only the valids are squashed.
            stateReg    <= EMPTY;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
        end else begin
            case (stateReg)
                EMPTY: begin
                    if (accept) begin
                        mainReg     <= inData;
                        outValidReg <= 1'b1;
                        stateReg    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        mainReg <= inData;
                    end else if (accept) begin
                        skidReg    <= inData;
                        inReadyReg <= 1'b0;
                        stateReg   <= TWO;
                    end else if (drain) begin
                        outValidReg <= 1'b0;
                        stateReg    <= EMPTY;
                    end
                end
                TWO: begin
                    // inReady is low here, so no accept can coincide with this drain.
                    if (drain) begin
                        mainReg    <= skidReg;
                        inReadyReg <= 1'b1;
                        stateReg   <= ONE;
                    end
                end
                default: begin
                    stateReg    <= EMPTY;
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: slices and classifies the fetched word, then holds
// the decoded record in a skid buffer feeding execute.
module instr_decode_stage
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inInstr,
    input  logic [DATA_WIDTH-1:0] inPc,
    input  logic                  flush,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outPc,
    output logic [5:0]            outOpcode,
    output logic [4:0]            outRd,
    output logic [4:0]            outRs,
    output logic [4:0]            outRt,
    output logic [IMM_WIDTH-1:0]  outImm,
    output logic                  outIsImm,
    output logic                  outIllegal
);

    decodedInstrT decoded;
    decodedInstrT held;
    logic         isRType;
    logic         isIType;

    always_comb begin
        decoded        = '0;
        decoded.pc     = inPc;
        decoded.opcode = inInstr[OPCODE_HI:OPCODE_LO];
        decoded.rd     = inInstr[RD_HI:RD_LO];
        decoded.rs     = inInstr[RS_HI:RS_LO];
        decoded.rt     = inInstr[RT_HI:RT_LO];
        decoded.imm    = inInstr[IMM_HI:IMM_LO];

        isRType = (decoded.opcode == OP_RTYPE);
        isIType = (decoded.opcode >= OP_IMM_LO) && (decoded.opcode <= OP_IMM_HI);

        decoded.isImm   = isIType;
        decoded.illegal = !(isRType || isIType);
    end

    instr_skid_buffer #(
        .T(decodedInstrT)
    ) skidBuffer (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (decoded),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (held)
    );

    assign outPc      = held.pc;
    assign outOpcode  = held.opcode;
    assign outRd      = held.rd;
    assign outRs      = held.rs;
    assign outRt      = held.rt;
    assign outImm     = held.imm;
    assign outIsImm   = held.isImm;
    assign outIllegal = held.illegal;

endmodule
